// File: rtl/mem_dump_reader.sv
// Read-side sweep sequencer: issues one memory read per word over a contiguous,
// wrapping address range and streams {addr, data} pairs through a 2-entry buffer.
module mem_dump_reader #(
    parameter int width  = 32,
    parameter int depth  = 32,
    parameter int addr_w = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base,
    input  logic [addr_w:0]   count,
    output logic              busy,
    output logic              done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [width-1:0]  m_data,
    output logic [addr_w-1:0] m_addr,
    output logic              mem_rd_en,
    output logic [addr_w-1:0] mem_raddr,
    output logic              mem_write,
    input  logic [width-1:0]  mem_rdata
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t              state_q, state_d;
    logic [addr_w-1:0]   next_addr_q, next_addr_d;
    logic [addr_w:0]     remaining_q, remaining_d;
    logic                inflight_q, inflight_d;
    logic [addr_w-1:0]   infl_addr_q, infl_addr_d;
    logic [1:0]          fifo_cnt_q, fifo_cnt_d;
    logic [addr_w-1:0]   e0_addr_q, e0_addr_d, e1_addr_q, e1_addr_d;
    logic [width-1:0]    e0_data_q, e0_data_d, e1_data_q, e1_data_d;
    logic                done_q, done_d;

    logic                push, pop, issue, last_pop;
    logic [2:0]          occ;
    logic [addr_w-1:0]   addr_inc;

    assign push     = inflight_q;
    assign pop      = (fifo_cnt_q != 2'd0) && m_ready;
    // A word leaving this cycle frees its slot, so back-to-back issue sustains one word per cycle.
    assign occ      = 3'(fifo_cnt_q) + 3'(inflight_q) - 3'(pop);
    assign addr_inc = (next_addr_q == addr_w'(depth - 1)) ? '0 : next_addr_q + addr_w'(1);
    assign last_pop = (fifo_cnt_q == 2'd1) && !inflight_q && pop;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start && count != '0) state_d = RUN;
            RUN:     if (issue && remaining_q == (addr_w+1)'(1)) state_d = DRAIN;
            DRAIN:   if (last_pop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        busy  = (state_q != IDLE);
        issue = (state_q == RUN) && (remaining_q != '0) && (occ < 3'd2);
    end

    assign mem_rd_en = issue;
    assign mem_raddr = next_addr_q;
    assign mem_write = 1'b0;
    assign m_valid   = (fifo_cnt_q != 2'd0);
    assign m_addr    = e0_addr_q;
    assign m_data    = e0_data_q;
    assign done      = done_q;

    // Datapath next values
    always_comb begin
        next_addr_d = next_addr_q;
        remaining_d = remaining_q;
        inflight_d  = issue;
        infl_addr_d = infl_addr_q;
        fifo_cnt_d  = fifo_cnt_q;
        e0_addr_d   = e0_addr_q;
        e0_data_d   = e0_data_q;
        e1_addr_d   = e1_addr_q;
        e1_data_d   = e1_data_q;
        done_d      = 1'b0;

        if (state_q == IDLE && start) begin
            if (count != '0) begin
                next_addr_d = base;
                remaining_d = count;
            end else begin
                done_d = 1'b1;
            end
        end

        if (issue) begin
            next_addr_d = addr_inc;
            remaining_d = remaining_q - (addr_w+1)'(1);
            infl_addr_d = next_addr_q;
        end

        if (state_q == DRAIN && last_pop) begin
            done_d = 1'b1;
        end

        // Head is always e0; e1 shifts forward on pop.
        case ({push, pop})
            2'b10: begin
                if (fifo_cnt_q == 2'd0) begin
                    e0_addr_d = infl_addr_q;
                    e0_data_d = mem_rdata;
                end else begin
                    e1_addr_d = infl_addr_q;
                    e1_data_d = mem_rdata;
                end
                fifo_cnt_d = fifo_cnt_q + 2'd1;
            end
            2'b01: begin
                e0_addr_d  = e1_addr_q;
                e0_data_d  = e1_data_q;
                fifo_cnt_d = fifo_cnt_q - 2'd1;
            end
            2'b11: begin
                if (fifo_cnt_q == 2'd1) begin
                    e0_addr_d = infl_addr_q;
                    e0_data_d = mem_rdata;
                end else begin
                    e0_addr_d = e1_addr_q;
                    e0_data_d = e1_data_q;
                    e1_addr_d = infl_addr_q;
                    e1_data_d = mem_rdata;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            next_addr_q <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            infl_addr_q <= '0;
            fifo_cnt_q  <= 2'd0;
            e0_addr_q   <= '0;
            e0_data_q   <= '0;
            e1_addr_q   <= '0;
            e1_data_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            next_addr_q <= next_addr_d;
            remaining_q <= remaining_d;
            inflight_q  <= inflight_d;
            infl_addr_q <= infl_addr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            e0_addr_q   <= e0_addr_d;
            e0_data_q   <= e0_data_d;
            e1_addr_q   <= e1_addr_d;
            e1_data_q   <= e1_data_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed bench for mem_dump_reader with a one-cycle-latency memory model.
module tb_mem_dump_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  base;
    logic [5:0]  count;
    logic        busy, done, m_valid, m_ready;
    logic [31:0] m_data;
    logic [4:0]  m_addr;
    logic        mem_rd_en, mem_write;
    logic [4:0]  mem_raddr;
    logic [31:0] mem_rdata;

    logic [31:0] mem [32];
    logic [4:0]  rec_a [$];
    logic [31:0] rec_d [$];

    int checks = 0;
    int errors = 0;
    int outst = 0;
    int hold_viol = 0, gate_viol = 0, ovf_viol = 0, mw_viol = 0;
    int rd_en_seen = 0;
    logic        prev_stall = 1'b0;
    logic [4:0]  prev_a;
    logic [31:0] prev_d;

    mem_dump_reader #(.width(32), .depth(32), .addr_w(5)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
        .busy(busy), .done(done), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_addr(m_addr), .mem_rd_en(mem_rd_en),
        .mem_raddr(mem_raddr), .mem_write(mem_write), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_rd_en) mem_rdata <= mem[mem_raddr];
    end

    // Outstanding words = issued reads not yet accepted (buffer + inflight).
    always @(posedge clk or posedge reset) begin
        if (reset) outst <= 0;
        else outst <= outst + (mem_rd_en ? 1 : 0) - ((m_valid && m_ready) ? 1 : 0);
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (m_valid && m_ready) begin
                rec_a.push_back(m_addr);
                rec_d.push_back(m_data);
            end
            if (prev_stall && (!m_valid || m_addr !== prev_a || m_data !== prev_d)) hold_viol++;
            if (!m_ready && outst == 2 && mem_rd_en) gate_viol++;
            if (outst > 2) ovf_viol++;
            if (mem_rd_en) rd_en_seen++;
            prev_stall = m_valid && !m_ready;
            prev_a = m_addr;
            prev_d = m_data;
        end else begin
            prev_stall = 1'b0;
        end
        if (mem_write !== 1'b0) mw_viol++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input string tag, input int limit, input bit rnd_ready);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < limit) begin
            if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
            tick();
            n++;
            if (done) seen = 1'b1;
        end
        chk({tag, "_done_in_time"}, 32'(seen), 32'd1);
        m_ready = 1'b1;
    endtask

    task automatic chk_seq(input string tag, input int from, input int n, input int first);
        int got = rec_a.size() - from;
        chk({tag, "_word_count"}, 32'(got), 32'(n));
        for (int k = 0; k < n && k < got; k++) begin
            chk({tag, "_addr"}, 32'(rec_a[from+k]), 32'((first + k) % 32));
            chk({tag, "_data"}, rec_d[from+k], mem[(first + k) % 32]);
        end
    endtask

    task automatic do_start(input logic [4:0] b, input logic [5:0] c);
        start = 1'b1;
        base  = b;
        count = c;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int from;
        int rd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'h100 + 32'(i) * 32'd7;
        mem[10] = 32'd144;
        mem[11] = 32'd170;
        mem[12] = 32'd200;
        mem[13] = 32'd210;
        mem_rdata = '0;
        reset = 1'b1; start = 1'b0; base = '0; count = '0; m_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_m_valid", 32'(m_valid), 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_m_addr", 32'(m_addr), 0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 0);
        chk("rst_mem_raddr", 32'(mem_raddr), 0);
        chk("rst_mem_write", 32'(mem_write), 0);

        // Basic sweep: one word per cycle, first word 3 edges after start.
        do_start(5'd10, 6'd4);
        chk("s1_busy_e0", 32'(busy), 1);
        chk("s1_rd_en_e0", 32'(mem_rd_en), 1);
        chk("s1_raddr_e0", 32'(mem_raddr), 10);
        tick();
        chk("s1_valid_e1", 32'(m_valid), 0);
        tick();
        chk("s1_valid_e2", 32'(m_valid), 1);
        chk("s1_addr_e2", 32'(m_addr), 10);
        chk("s1_data_e2", m_data, 144);
        tick();
        chk("s1_addr_e3", 32'(m_addr), 11);
        chk("s1_data_e3", m_data, 170);
        tick();
        chk("s1_addr_e4", 32'(m_addr), 12);
        chk("s1_data_e4", m_data, 200);
        tick();
        chk("s1_addr_e5", 32'(m_addr), 13);
        chk("s1_data_e5", m_data, 210);
        chk("s1_done_e5", 32'(done), 0);
        chk("s1_busy_e5", 32'(busy), 1);
        tick();
        chk("s1_done_e6", 32'(done), 1);
        chk("s1_busy_e6", 32'(busy), 0);
        chk("s1_valid_e6", 32'(m_valid), 0);
        tick();
        chk("s1_done_e7", 32'(done), 0);

        // Wrap past depth-1.
        from = rec_a.size();
        do_start(5'd30, 6'd4);
        wait_done("wrap", 40, 1'b0);
        chk_seq("wrap", from, 4, 30);
        tick();

        // Backpressure after the first word.
        from = rec_a.size();
        do_start(5'd10, 6'd4);
        tick(); tick();
        chk("bp_first_valid", 32'(m_valid), 1);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_addr", 32'(m_addr), 10);
            chk("bp_hold_data", m_data, 144);
        end
        chk("bp_rd_en_stalled", 32'(mem_rd_en), 0);
        m_ready = 1'b1;
        wait_done("bp", 40, 1'b0);
        chk_seq("bp", from, 4, 10);
        chk("bp_hold_viol", 32'(hold_viol), 0);
        chk("bp_gate_viol", 32'(gate_viol), 0);
        tick();

        // count == 0.
        rd0 = rd_en_seen;
        do_start(5'd7, 6'd0);
        chk("c0_done", 32'(done), 1);
        chk("c0_busy", 32'(busy), 0);
        chk("c0_rd_en", 32'(mem_rd_en), 0);
        tick();
        chk("c0_done_after", 32'(done), 0);
        chk("c0_busy_after", 32'(busy), 0);
        chk("c0_no_reads", 32'(rd_en_seen - rd0), 0);

        // Start during RUN is ignored; reset mid-sweep.
        do_start(5'd10, 6'd4);
        do_start(5'd0, 6'd2);
        chk("ign_raddr", 32'(mem_raddr), 11);
        chk("ign_busy", 32'(busy), 1);
        tick();
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_m_valid", 32'(m_valid), 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_m_addr", 32'(m_addr), 0);
        chk("mid_rst_rd_en", 32'(mem_rd_en), 0);
        chk("mid_rst_raddr", 32'(mem_raddr), 0);
        chk("mid_rst_done", 32'(done), 0);
        tick();
        reset = 1'b0;
        tick();
        from = rec_a.size();
        do_start(5'd0, 6'd2);
        wait_done("after_rst", 40, 1'b0);
        tick(); tick();
        chk_seq("after_rst", from, 2, 0);

        // Full sweep with random backpressure.
        from = rec_a.size();
        do_start(5'd0, 6'd32);
        wait_done("full", 2000, 1'b1);
        chk_seq("full", from, 32, 0);
        chk("full_hold_viol", 32'(hold_viol), 0);
        chk("full_gate_viol", 32'(gate_viol), 0);
        chk("full_overflow", 32'(ovf_viol), 0);
        chk("mem_write_zero", 32'(mw_viol), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
